// File: rtl/hw2_alu_pkg.sv
// Shared definitions for the hw2 ALU issuer: instruction codes, bus widths,
// the packed command layout and the issuer FSM state encoding.
package hw2_alu_pkg;

   localparam int ALU_A_W    = 8;
   localparam int ALU_INST_W = 3;
   localparam int ALU_RES_W  = 16;
   localparam int CMD_W      = 2 * ALU_A_W + ALU_INST_W;

   typedef enum logic [ALU_INST_W-1:0] {
      INST_ADD   = 3'd0,
      INST_SUB   = 3'd1,
      INST_MUL   = 3'd2,
      INST_AND   = 3'd3,
      INST_XOR   = 3'd4,
      INST_ABS   = 3'd5,
      INST_SUBX4 = 3'd6,
      INST_IDLE  = 3'd7
   } alu_inst_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } issuer_state_e;

   typedef struct packed {
      logic [ALU_A_W-1:0]    a;
      logic [ALU_A_W-1:0]    b;
      logic [ALU_INST_W-1:0] inst;
   } alu_cmd_t;

endpackage

// File: rtl/hw2_alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty/level; pointers wrap naturally
// because DEPTH is a power of two.
module hw2_alu_cmd_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [W-1:0]                 data_i,
   input  logic                         pop_i,
   output logic [W-1:0]                 data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      level_d = level_q;
      if (push_ok && !pop_ok) level_d = level_q + LVL_W'(1);
      else if (!push_ok && pop_ok) level_d = level_q - LVL_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/hw2_alu_issuer.sv
// Issues queued ALU commands one at a time and returns the registered result.
// Build option: HW2_ALU_ILLEGAL_CHK_EN rejects inst==3'b111 with rsp_err_o.
module hw2_alu_issuer
   import hw2_alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ALU_LAT    = 1
) (
   input  logic                              clk_p_i,
   input  logic                              reset_p_i,
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic [ALU_A_W-1:0]                cmd_a_i,
   input  logic [ALU_A_W-1:0]                cmd_b_i,
   input  logic [ALU_INST_W-1:0]             cmd_inst_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   cmd_level_o,
   output logic [ALU_A_W-1:0]                alu_data_a_o,
   output logic [ALU_A_W-1:0]                alu_data_b_o,
   output logic [ALU_INST_W-1:0]             alu_inst_o,
   input  logic [ALU_RES_W-1:0]              alu_data_i,
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [ALU_RES_W-1:0]              rsp_data_o,
   output logic [ALU_INST_W-1:0]             rsp_inst_o,
   output logic                              rsp_err_o,
   output logic                              busy_o
);

   localparam int CNT_W = $clog2(ALU_LAT + 2);

   // Both ports transfer on a rising edge where valid and ready are high; a
   // presented response holds its payload until that edge.
   issuer_state_e         state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ALU_A_W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [ALU_INST_W-1:0] alu_inst_q, alu_inst_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [ALU_RES_W-1:0]  rsp_data_q, rsp_data_d;
   logic [ALU_INST_W-1:0] rsp_inst_q, rsp_inst_d;

   logic                  fifo_full, fifo_empty, fifo_pop, illegal;
   logic [CMD_W-1:0]      fifo_rdata;
   alu_cmd_t              head_cmd;

   hw2_alu_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_p_i),
      .rst_i   (reset_p_i),
      .push_i  (cmd_valid_i),
      .data_i  ({cmd_a_i, cmd_b_i, cmd_inst_i}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (cmd_level_o)
   );

   assign head_cmd = alu_cmd_t'(fifo_rdata);

`ifdef HW2_ALU_ILLEGAL_CHK_EN
   assign illegal = (head_cmd.inst == INST_IDLE);
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_inst_d  = alu_inst_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_inst_d  = rsp_inst_q;
      rsp_err_d   = rsp_err_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (illegal) begin
                  // Rejected command never reaches the ALU.
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_inst_d  = INST_IDLE;
                  rsp_err_d   = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  alu_a_d    = head_cmd.a;
                  alu_b_d    = head_cmd.b;
                  alu_inst_d = head_cmd.inst;
                  cnt_d      = CNT_W'(ALU_LAT);
                  state_d    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = alu_data_i;
               rsp_inst_d  = alu_inst_q;
               rsp_err_d   = 1'b0;
               alu_a_d     = '0;
               alu_b_d     = '0;
               alu_inst_d  = INST_IDLE;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_inst_q  <= INST_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_inst_q  <= INST_IDLE;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_inst_q  <= alu_inst_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_inst_q  <= rsp_inst_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready_o  = !fifo_full;
   assign alu_data_a_o = alu_a_q;
   assign alu_data_b_o = alu_b_q;
   assign alu_inst_o   = alu_inst_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_inst_o   = rsp_inst_q;
   assign rsp_err_o    = rsp_err_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hw2_alu_issuer.sv
// Bench for hw2_alu_issuer with a behavioural HW2 ALU behind it; follows the
// HW2_ALU_ILLEGAL_CHK_EN build option for the rejected-instruction case.
module tb_hw2_alu_issuer;
   import hw2_alu_pkg::*;

`ifdef HW2_ALU_ILLEGAL_CHK_EN
   localparam logic ILL_ERR = 1'b1;
`else
   localparam logic ILL_ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_a, cmd_b;
   logic [2:0]  cmd_inst;
   logic [2:0]  cmd_level;
   logic [7:0]  alu_a, alu_b;
   logic [2:0]  alu_inst;
   logic [15:0] alu_q;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_inst;

   int          checks = 0;
   int          errors = 0;
   logic [19:0] exp_q[$];   // {err, inst, data}
   logic        stall_q = 1'b0;
   logic [19:0] stall_val = '0;

   always #5 clk = ~clk;

   hw2_alu_issuer #(.FIFO_DEPTH(4), .ALU_LAT(1)) dut (
      .clk_p_i      (clk),
      .reset_p_i    (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_a_i      (cmd_a),
      .cmd_b_i      (cmd_b),
      .cmd_inst_i   (cmd_inst),
      .cmd_level_o  (cmd_level),
      .alu_data_a_o (alu_a),
      .alu_data_b_o (alu_b),
      .alu_inst_o   (alu_inst),
      .alu_data_i   (alu_q),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_data_o   (rsp_data),
      .rsp_inst_o   (rsp_inst),
      .rsp_err_o    (rsp_err),
      .busy_o       (busy)
   );

   // Behavioural HW2 ALU: one registered stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) alu_q <= '0;
      else begin
         case (alu_inst)
            3'd0: alu_q <= {8'd0, alu_a} + {8'd0, alu_b};
            3'd1: alu_q <= {8'd0, alu_a} - {8'd0, alu_b};
            3'd2: alu_q <= {8'd0, alu_a} * {8'd0, alu_b};
            3'd3: alu_q <= {8'd0, alu_a & alu_b};
            3'd4: alu_q <= {8'd0, alu_a ^ alu_b};
            3'd5: alu_q <= {8'd0, alu_a[7] ? (~alu_a + 8'd1) : alu_a};
            3'd6: alu_q <= ({8'd0, alu_a} - {8'd0, alu_b}) << 2;
            default: alu_q <= '0;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: compares every handshake against the scoreboard and
   // checks the payload is frozen while the consumer stalls.
   always @(negedge clk) begin
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            check("rsp_hold_payload", 32'({rsp_err, rsp_inst, rsp_data}), 32'(stall_val));
         end
         if (rsp_valid && !rsp_ready) begin
            stall_q   = 1'b1;
            stall_val = {rsp_err, rsp_inst, rsp_data};
         end else begin
            stall_q = 1'b0;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got 0x%0h expected no response", {rsp_err, rsp_inst, rsp_data});
            end else begin
               check("rsp_payload", 32'({rsp_err, rsp_inst, rsp_data}), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] inst,
                       input logic [15:0] exp_data, input logic exp_err);
      logic acc, accepted;
      accepted  = 1'b0;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_inst  = inst;
      for (int i = 0; i < 300 && !accepted; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         if (acc) accepted = 1'b1;
      end
      if (accepted) exp_q.push_back({exp_err, inst, exp_data});
      else begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept for inst %0d", inst);
      end
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_level"}, 32'(cmd_level), 32'd0);
      check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      check({tag, "_alu_inst"}, 32'(alu_inst), 32'd7);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_rsp_inst"}, 32'(rsp_inst), 32'd7);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_inst  = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Latency: accept at edge N, valid visible after edge N+3.
      send(8'd200, 8'd100, 3'd0, 16'd300, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("lat_not_yet", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_valid", 32'(rsp_valid), 32'd1);
      check("lat_data", 32'(rsp_data), 32'd300);
      check("lat_inst", 32'(rsp_inst), 32'd0);
      drain();

      // Back-to-back commands, in-order responses.
      send(8'hFF, 8'hFF, 3'd2, 16'hFE01, 1'b0);
      send(8'd5,  8'd10, 3'd1, 16'hFFFB, 1'b0);
      send(8'hF0, 8'h3C, 3'd3, 16'h0030, 1'b0);
      send(8'hF0, 8'h3C, 3'd4, 16'h00CC, 1'b0);
      send(8'hFF, 8'h01, 3'd0, 16'h0100, 1'b0);
      send(8'h80, 8'h00, 3'd5, 16'h0080, 1'b0);
      send(8'd9,  8'd4,  3'd6, 16'h0014, 1'b0);
      drain();

      // Stalled consumer: one response parked plus four queued fills the path.
      rsp_ready = 1'b0;
      send(8'd1,  8'd2,  3'd0, 16'h0003, 1'b0);
      send(8'd3,  8'd4,  3'd0, 16'h0007, 1'b0);
      send(8'h10, 8'h10, 3'd2, 16'h0100, 1'b0);
      send(8'd0,  8'd1,  3'd1, 16'hFFFF, 1'b0);
      send(8'hAA, 8'h55, 3'd4, 16'h00FF, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("full_level", 32'(cmd_level), 32'd4);
      check("full_busy", 32'(busy), 32'd1);
      check("full_rsp_valid", 32'(rsp_valid), 32'd1);
      fork
         begin
            repeat (6) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
         send(8'hFF, 8'h0F, 3'd3, 16'h000F, 1'b0);
      join
      drain();

      // Instruction code 3'b111.
      send(8'h55, 8'h0A, 3'd7, 16'h0000, ILL_ERR);
`ifdef HW2_ALU_ILLEGAL_CHK_EN
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ill_alu_inst_idle", 32'(alu_inst), 32'd7);
         check("ill_alu_a_idle", 32'(alu_a), 32'd0);
      end
`endif
      drain();

      // Reset while a command is in WAIT with two more queued.
      send(8'd1, 8'd1, 3'd0, 16'd2, 1'b0);
      send(8'd2, 8'd2, 3'd0, 16'd4, 1'b0);
      send(8'd3, 8'd3, 3'd0, 16'd6, 1'b0);
      check("pre_reset_busy", 32'(busy), 32'd1);
      check("pre_reset_level", 32'(cmd_level), 32'd2);
      check("pre_reset_no_rsp", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check("post_reset_level", 32'(cmd_level), 32'd0);

      // Traffic resumes cleanly after reset.
      send(8'd7, 8'd8, 3'd0, 16'd15, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
